fetch_unit: RTL and testbench

Instruction fetch front end for the 6502 core. Reads the opcode byte and the two following bytes from program memory at the program counter and presents them to the decoder with a one-cycle `instruction_ready` pulse. It holds the bundle until the decoder returns `get_next`, then advances the PC by the consumed instruction length. It also owns PC redirection for jumps and branches, and the optional reset-vector load.

---
 rtl/fetch_unit_pkg.sv | 27 ++
 rtl/fetch_unit.sv | 182 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the 6502 instruction fetch front end: widths,
// default addresses and the 4-bit FSM state encoding.
package fetch_unit_pkg;

    localparam int          FU_ADDR_WIDTH  = 16;
    localparam int          FU_REG_WIDTH   = 8;
    localparam logic [15:0] FU_VECTOR_ADDR = 16'hFFFC;
    localparam logic [15:0] FU_RESET_PC    = 16'h0200;

    typedef enum logic [3:0] {
        ST_VEC_LO    = 4'd0,
        ST_VEC_HI    = 4'd1,
        ST_VEC_END   = 4'd2,
        ST_FETCH_OP  = 4'd3,
        ST_FETCH_B1  = 4'd4,
        ST_FETCH_B2  = 4'd5,
        ST_FETCH_END = 4'd6,
        ST_PRESENT   = 4'd7,
        ST_WAIT      = 4'd8
    } fetch_state_t;

    // A zero-length report from the decoder still has to move past the opcode.
    function automatic logic [1:0] eff_len(input logic [1:0] len);
        return (len == 2'd0) ? 2'd1 : len;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch front end: reads opcode + two operand bytes at the PC and
// hands them to the decoder. Reset-vector load is enabled by FETCH_RESET_VECTOR_EN.
//
// state        | meaning
// VEC_LO       | issue low vector byte address
// VEC_HI       | capture low vector byte, issue high byte address
// VEC_END      | capture high vector byte into PC
// FETCH_OP     | issue PC
// FETCH_B1     | capture opcode, issue PC+1
// FETCH_B2     | capture byte1, issue PC+2
// FETCH_END    | capture byte2, publish the bundle
// PRESENT      | instruction_ready pulse
// WAIT         | hold bundle until get_next / pc_load
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = FU_ADDR_WIDTH,
    parameter int                    REG_WIDTH   = FU_REG_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(FU_RESET_PC),
    parameter logic [ADDR_WIDTH-1:0] VECTOR_ADDR = ADDR_WIDTH'(FU_VECTOR_ADDR)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [REG_WIDTH-1:0]  mem_rdata,
    output logic [REG_WIDTH-1:0]  instruction_out,
    output logic [ADDR_WIDTH-1:0] address_out,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  instruction_ready,
    input  logic                  get_next,
    input  logic [1:0]            instr_len,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_target
);

`ifdef FETCH_RESET_VECTOR_EN
    localparam fetch_state_t          RESET_STATE = ST_VEC_LO;
    localparam logic [ADDR_WIDTH-1:0] PC_INIT     = '0;
    logic [ADDR_WIDTH-1:0] unused_reset_pc;
    assign unused_reset_pc = RESET_PC;
`else
    localparam fetch_state_t          RESET_STATE = ST_FETCH_OP;
    localparam logic [ADDR_WIDTH-1:0] PC_INIT     = RESET_PC;
    logic [ADDR_WIDTH-1:0] unused_vector_addr;
    assign unused_vector_addr = VECTOR_ADDR;
`endif

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [REG_WIDTH-1:0]  op_q, op_d;
    logic [REG_WIDTH-1:0]  b1_q, b1_d;
    logic [REG_WIDTH-1:0]  instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] opnd_q, opnd_d;
    logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
`ifdef FETCH_RESET_VECTOR_EN
    logic [REG_WIDTH-1:0]  vec_lo_q, vec_lo_d;
`endif

    logic accept_next;
    logic redirect;

    assign accept_next = get_next && (state_q == ST_PRESENT || state_q == ST_WAIT);
    assign redirect    = pc_load &&
                         !(state_q inside {ST_VEC_LO, ST_VEC_HI, ST_VEC_END});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RESET_STATE;
            pc_q     <= PC_INIT;
            op_q     <= '0;
            b1_q     <= '0;
            instr_q  <= '0;
            opnd_q   <= '0;
            pc_out_q <= '0;
`ifdef FETCH_RESET_VECTOR_EN
            vec_lo_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            op_q     <= op_d;
            b1_q     <= b1_d;
            instr_q  <= instr_d;
            opnd_q   <= opnd_d;
            pc_out_q <= pc_out_d;
`ifdef FETCH_RESET_VECTOR_EN
            vec_lo_q <= vec_lo_d;
`endif
        end
    end

    always_comb begin
        state_d           = state_q;
        pc_d              = pc_q;
        op_d              = op_q;
        b1_d              = b1_q;
        instr_d           = instr_q;
        opnd_d            = opnd_q;
        pc_out_d          = pc_out_q;
`ifdef FETCH_RESET_VECTOR_EN
        vec_lo_d          = vec_lo_q;
`endif
        mem_rd            = 1'b0;
        mem_addr          = '0;
        instruction_ready = 1'b0;

        case (state_q)
`ifdef FETCH_RESET_VECTOR_EN
            ST_VEC_LO: begin
                mem_rd   = 1'b1;
                mem_addr = VECTOR_ADDR;
                state_d  = ST_VEC_HI;
            end
            ST_VEC_HI: begin
                vec_lo_d = mem_rdata;
                mem_rd   = 1'b1;
                mem_addr = VECTOR_ADDR + ADDR_WIDTH'(1);
                state_d  = ST_VEC_END;
            end
            ST_VEC_END: begin
                pc_d    = ADDR_WIDTH'({mem_rdata, vec_lo_q});
                state_d = ST_FETCH_OP;
            end
`endif
            ST_FETCH_OP: begin
                mem_rd   = 1'b1;
                mem_addr = pc_q;
                state_d  = ST_FETCH_B1;
            end
            ST_FETCH_B1: begin
                op_d     = mem_rdata;
                mem_rd   = 1'b1;
                mem_addr = pc_q + ADDR_WIDTH'(1);
                state_d  = ST_FETCH_B2;
            end
            ST_FETCH_B2: begin
                b1_d     = mem_rdata;
                mem_rd   = 1'b1;
                mem_addr = pc_q + ADDR_WIDTH'(2);
                state_d  = ST_FETCH_END;
            end
            ST_FETCH_END: begin
                instr_d  = op_q;
                opnd_d   = ADDR_WIDTH'({mem_rdata, b1_q});
                pc_out_d = pc_q;
                state_d  = ST_PRESENT;
            end
            ST_PRESENT: begin
                instruction_ready = 1'b1;
                state_d           = ST_WAIT;
            end
            ST_WAIT: begin
                state_d = ST_WAIT;
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase

        if (accept_next) begin
            pc_d    = pc_q + ADDR_WIDTH'(eff_len(instr_len));
            state_d = ST_FETCH_OP;
        end

        // Redirect beats get_next and throws away anything fetched so far,
        // including a bundle that would have been published this cycle.
        if (redirect) begin
            pc_d              = pc_target;
            state_d           = ST_FETCH_OP;
            instr_d           = instr_q;
            opnd_d            = opnd_q;
            pc_out_d          = pc_out_q;
            instruction_ready = 1'b0;
        end
    end

    assign instruction_out = instr_q;
    assign address_out     = opnd_q;
    assign pc_out          = pc_out_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a memory array and a PC-level
// reference model; builds with or without FETCH_RESET_VECTOR_EN.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  instruction_out;
    logic [15:0] address_out;
    logic [15:0] pc_out;
    logic        instruction_ready;
    logic        get_next = 1'b0;
    logic [1:0]  instr_len = 2'd0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_target = 16'h0000;

    fetch_unit dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .mem_addr          (mem_addr),
        .mem_rd            (mem_rd),
        .mem_rdata         (mem_rdata),
        .instruction_out   (instruction_out),
        .address_out       (address_out),
        .pc_out            (pc_out),
        .instruction_ready (instruction_ready),
        .get_next          (get_next),
        .instr_len         (instr_len),
        .pc_load           (pc_load),
        .pc_target         (pc_target)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    always @(posedge clk) mem_rdata <= mem[mem_addr];

`ifdef FETCH_RESET_VECTOR_EN
    localparam logic [15:0] EXP_START = 16'h8000;
    localparam logic [15:0] RST_ADDR  = 16'hFFFC;
    localparam int          BOOT      = 3;
`else
    localparam logic [15:0] EXP_START = 16'h0200;
    localparam logic [15:0] RST_ADDR  = 16'h0200;
    localparam int          BOOT      = 0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_pc;

    logic [15:0] o_addr [0:15];
    logic        o_rd   [0:15];
    logic        o_rdy  [0:15];
    logic [7:0]  o_instr;
    logic [15:0] o_opnd;
    logic [15:0] o_pc;

    function automatic logic [15:0] opnd_at(input logic [15:0] p);
        logic [15:0] a1, a2;
        a1 = p + 16'd1;
        a2 = p + 16'd2;
        return {mem[a2], mem[a1]};
    endfunction

    function automatic logic [15:0] step(input logic [15:0] p, input logic [1:0] len);
        return p + ((len == 2'd0) ? 16'd1 : 16'(len));
    endfunction

    // Record n cycles (sampled just after each falling edge); optionally pulse
    // pc_load at cycle load_at and get_next at cycle gn_at.
    task automatic observe(input int n, input int load_at, input logic [15:0] tgt,
                           input int gn_at, input logic [1:0] gn_len);
        o_instr = 'x; o_opnd = 'x; o_pc = 'x;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            get_next = 1'b0;
            pc_load  = 1'b0;
            if (k == load_at) begin pc_load = 1'b1; pc_target = tgt; end
            if (k == gn_at) begin get_next = 1'b1; instr_len = gn_len; end
            #1;
            o_addr[k] = mem_addr;
            o_rd[k]   = mem_rd;
            o_rdy[k]  = instruction_ready;
            if (instruction_ready) begin
                o_instr = instruction_out; o_opnd = address_out; o_pc = pc_out;
            end
        end
    endtask

    task automatic test_reset();
        int early;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (instruction_out !== 8'h00 || address_out !== 16'h0000 || pc_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got instr=%h opnd=%h pc=%h, expected all zero",
                     instruction_out, address_out, pc_out);
        end
        n_checks++;
        if (instruction_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 0", instruction_ready);
        end
        n_checks++;
        if (mem_rd !== 1'b1 || mem_addr !== RST_ADDR) begin
            n_fail++;
            $display("FAIL reset_addr: got rd=%b addr=%h expected rd=1 addr=%h", mem_rd, mem_addr, RST_ADDR);
        end
        @(negedge clk);
        reset_n = 1'b1;
        exp_pc = EXP_START;
        observe(BOOT + 5, 0, 16'h0, 0, 2'd0);
`ifdef FETCH_RESET_VECTOR_EN
        n_checks++;
        if (o_addr[1] !== 16'hFFFD || o_rd[2] !== 1'b0 || o_addr[3] !== 16'h8000) begin
            n_fail++;
            $display("FAIL vector_seq: got hi=%h end_rd=%b first=%h expected FFFD 0 8000",
                     o_addr[1], o_rd[2], o_addr[3]);
        end
`endif
        early = 0;
        for (int k = 1; k < BOOT + 4; k++) if (o_rdy[k] !== 1'b0) early++;
        n_checks++;
        if (early != 0 || o_rdy[BOOT+4] !== 1'b1 || o_rdy[BOOT+5] !== 1'b0) begin
            n_fail++;
            $display("FAIL boot_ready: early=%0d at=%b after=%b expected 0 1 0",
                     early, o_rdy[BOOT+4], o_rdy[BOOT+5]);
        end
        n_checks++;
        if (o_instr !== 8'hA9 || o_opnd !== 16'h0042 || o_pc !== EXP_START) begin
            n_fail++;
            $display("FAIL boot_bundle: got %h %h %h expected A9 0042 %h", o_instr, o_opnd, o_pc, EXP_START);
        end
    endtask

    task automatic test_get_next();
        logic [1:0] len;
        int d;
        for (int it = 0; it < 24; it++) begin
            len = (it == 0) ? 2'd2 : (it == 1) ? 2'd0 : 2'($urandom_range(0, 3));
            d   = (it < 2) ? 0 : $urandom_range(0, 3);
            for (int w = 0; w < d; w++) begin
                @(negedge clk); #1;
                n_checks++;
                if (instruction_ready !== 1'b0 || pc_out !== exp_pc) begin
                    n_fail++;
                    $display("FAIL wait_hold: got rdy=%b pc=%h expected 0 %h", instruction_ready, pc_out, exp_pc);
                end
            end
            get_next = 1'b1; instr_len = len;
            exp_pc = step(exp_pc, len);
            observe(6, 0, 16'h0, 0, 2'd0);
            n_checks++;
            if (o_rd[1] !== 1'b1 || o_addr[1] !== exp_pc || o_addr[2] !== exp_pc + 16'd1 ||
                o_addr[3] !== exp_pc + 16'd2) begin
                n_fail++;
                $display("FAIL fetch_addrs: got %h %h %h expected base %h", o_addr[1], o_addr[2], o_addr[3], exp_pc);
            end
            n_checks++;
            if (o_rd[4] !== 1'b0 || o_addr[4] !== 16'h0000) begin
                n_fail++; $display("FAIL fetch_end_idle: got rd=%b addr=%h expected 0 0000", o_rd[4], o_addr[4]);
            end
            n_checks++;
            if (o_rdy[1] || o_rdy[2] || o_rdy[3] || o_rdy[4] || o_rdy[5] !== 1'b1 || o_rdy[6] !== 1'b0) begin
                n_fail++;
                $display("FAIL ready_timing: got %b%b%b%b%b%b expected 000010",
                         o_rdy[1], o_rdy[2], o_rdy[3], o_rdy[4], o_rdy[5], o_rdy[6]);
            end
            n_checks++;
            if (o_instr !== mem[exp_pc] || o_opnd !== opnd_at(exp_pc) || o_pc !== exp_pc) begin
                n_fail++;
                $display("FAIL bundle: got %h %h %h expected %h %h %h",
                         o_instr, o_opnd, o_pc, mem[exp_pc], opnd_at(exp_pc), exp_pc);
            end
        end
    endtask

    task automatic test_back_to_back();
        get_next = 1'b1; instr_len = 2'd1;
        exp_pc = step(exp_pc, 2'd1);
        observe(5, 0, 16'h0, 0, 2'd0);
        get_next = 1'b1; instr_len = 2'd3;
        exp_pc = step(exp_pc, 2'd3);
        observe(6, 0, 16'h0, 0, 2'd0);
        n_checks++;
        if (o_addr[1] !== exp_pc || o_rdy[5] !== 1'b1 || o_pc !== exp_pc) begin
            n_fail++;
            $display("FAIL present_accept: got addr=%h rdy=%b pc=%h expected %h 1 %h", o_addr[1], o_rdy[5], o_pc, exp_pc, exp_pc);
        end
    endtask

    task automatic test_redirect_b1();
        int early;
        get_next = 1'b1; instr_len = 2'd2;
        exp_pc = step(exp_pc, 2'd2);
        observe(8, 2, 16'h1234, 0, 2'd0);
        early = 0;
        for (int k = 1; k <= 6; k++) if (o_rdy[k] !== 1'b0) early++;
        n_checks++;
        if (early != 0 || o_addr[3] !== 16'h1234 || o_rdy[7] !== 1'b1) begin
            n_fail++;
            $display("FAIL redirect_b1: stale=%0d addr=%h rdy=%b expected 0 1234 1", early, o_addr[3], o_rdy[7]);
        end
        exp_pc = 16'h1234;
        n_checks++;
        if (o_instr !== mem[exp_pc] || o_opnd !== opnd_at(exp_pc) || o_pc !== exp_pc) begin
            n_fail++; $display("FAIL redirect_bundle: got %h %h %h expected pc 1234", o_instr, o_opnd, o_pc);
        end
    endtask

    task automatic test_ready_suppress();
        logic [15:0] tgt;
        int early;
        tgt = 16'($urandom_range(0, 16'hFFF0));
        get_next = 1'b1; instr_len = 2'd1;
        exp_pc = step(exp_pc, 2'd1);
        observe(11, 5, tgt, 0, 2'd0);
        early = 0;
        for (int k = 1; k <= 9; k++) if (o_rdy[k] !== 1'b0) early++;
        n_checks++;
        if (early != 0 || o_addr[6] !== tgt || o_rdy[10] !== 1'b1 || o_pc !== tgt) begin
            n_fail++;
            $display("FAIL ready_suppress: stale=%0d addr=%h rdy=%b pc=%h expected 0 %h 1 %h",
                     early, o_addr[6], o_rdy[10], o_pc, tgt, tgt);
        end
        exp_pc = tgt;
    endtask

    task automatic test_load_and_next();
        pc_load = 1'b1; pc_target = EXP_START;
        observe(6, 0, 16'h0, 0, 2'd0);
        pc_load = 1'b1; pc_target = 16'h3000;
        get_next = 1'b1; instr_len = 2'd3;
        observe(6, 0, 16'h0, 0, 2'd0);
        exp_pc = 16'h3000;
        n_checks++;
        if (o_addr[1] !== 16'h3000 || o_rdy[5] !== 1'b1 || o_pc !== 16'h3000) begin
            n_fail++;
            $display("FAIL load_beats_next: got addr=%h rdy=%b pc=%h expected 3000 1 3000", o_addr[1], o_rdy[5], o_pc);
        end
    endtask

    task automatic test_ignored_next();
        get_next = 1'b1; instr_len = 2'd1;
        exp_pc = step(exp_pc, 2'd1);
        observe(6, 0, 16'h0, 2, 2'd3);
        n_checks++;
        if (o_rdy[5] !== 1'b1 || o_pc !== exp_pc) begin
            n_fail++; $display("FAIL ignored_next: got rdy=%b pc=%h expected 1 %h", o_rdy[5], o_pc, exp_pc);
        end
        get_next = 1'b1; instr_len = 2'd2;
        exp_pc = step(exp_pc, 2'd2);
        observe(6, 0, 16'h0, 0, 2'd0);
        n_checks++;
        if (o_addr[1] !== exp_pc) begin
            n_fail++; $display("FAIL ignored_next_pc: got %h expected %h", o_addr[1], exp_pc);
        end
    endtask

    task automatic test_wrap();
        pc_load = 1'b1; pc_target = 16'hFFFE;
        exp_pc = 16'hFFFE;
        observe(5, 0, 16'h0, 0, 2'd0);
        n_checks++;
        if (o_addr[1] !== 16'hFFFE || o_addr[2] !== 16'hFFFF || o_addr[3] !== 16'h0000) begin
            n_fail++; $display("FAIL wrap_addrs: got %h %h %h expected FFFE FFFF 0000", o_addr[1], o_addr[2], o_addr[3]);
        end
        n_checks++;
        if (o_instr !== mem[16'hFFFE] || o_opnd !== {mem[16'h0000], mem[16'hFFFF]} || o_pc !== 16'hFFFE) begin
            n_fail++; $display("FAIL wrap_bundle: got %h %h %h expected pc FFFE", o_instr, o_opnd, o_pc);
        end
        get_next = 1'b1; instr_len = 2'd3;
        exp_pc = 16'h0001;
        observe(6, 0, 16'h0, 0, 2'd0);
        n_checks++;
        if (o_addr[1] !== 16'h0001 || o_pc !== 16'h0001) begin
            n_fail++; $display("FAIL wrap_advance: got addr=%h pc=%h expected 0001", o_addr[1], o_pc);
        end
    endtask

    task automatic test_reset_midfetch();
        get_next = 1'b1; instr_len = 2'd1;
        observe(3, 0, 16'h0, 0, 2'd0);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (instruction_out !== 8'h00 || address_out !== 16'h0000 || pc_out !== 16'h0000 ||
            instruction_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midfetch_clear: got %h %h %h rdy=%b expected zeros",
                     instruction_out, address_out, pc_out, instruction_ready);
        end
        n_checks++;
        if (mem_rd !== 1'b1 || mem_addr !== RST_ADDR) begin
            n_fail++; $display("FAIL midfetch_addr: got rd=%b addr=%h expected 1 %h", mem_rd, mem_addr, RST_ADDR);
        end
        @(negedge clk);
        reset_n = 1'b1;
        exp_pc = EXP_START;
        observe(BOOT + 5, 0, 16'h0, 0, 2'd0);
        n_checks++;
        if (o_rdy[BOOT+4] !== 1'b1 || o_pc !== EXP_START || o_instr !== 8'hA9 || o_opnd !== 16'h0042) begin
            n_fail++;
            $display("FAIL midfetch_restart: got rdy=%b %h %h %h expected 1 A9 0042 %h",
                     o_rdy[BOOT+4], o_instr, o_opnd, o_pc, EXP_START);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        mem[16'hFFFC] = 8'h00;
        mem[16'hFFFD] = 8'h80;
        mem[EXP_START]         = 8'hA9;
        mem[EXP_START + 16'd1] = 8'h42;
        mem[EXP_START + 16'd2] = 8'h00;

        test_reset();
        test_get_next();
        test_back_to_back();
        test_redirect_b1();
        test_ready_suppress();
        test_load_and_next();
        test_ignored_next();
        test_wrap();
        test_reset_midfetch();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
